// File: rtl/fpu_requester.sv
// Initiator side of the FPU stb/ack handshake: latches one op, strobes both operands, waits for the result, pulses done.
// Optional watchdog: define FPU_TIMEOUT_EN to abort a stalled transaction after TIMEOUT_CYCLES.
module fpu_requester #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op_in,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        err,
    output logic [3:0]  fpu_op,
    output logic [31:0] fpu_in1,
    output logic [31:0] fpu_in2,
    output logic        fpu_in1_stb,
    output logic        fpu_in2_stb,
    input  logic        fpu_in1_ack,
    input  logic        fpu_in2_ack,
    input  logic [31:0] fpu_out,
    input  logic        fpu_out_stb,
    output logic        fpu_out_ack
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_OUT,
        ACK,
        ACK_ERR
    } state_t;

    localparam logic [3:0] LAST_OP = 4'b1010;

    state_t state;
    logic   got1;
    logic   got2;
    logic   both_acked;
    logic   wd_expired;

    // An ack counts in the cycle it is sampled, so simultaneous acks leave SEND at once.
    assign both_acked = (got1 | fpu_in1_ack) & (got2 | fpu_in2_ack);

`ifdef FPU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;

    // Fires on the last of TIMEOUT_CYCLES cycles spent in SEND/WAIT_OUT.
    assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (state == SEND || state == WAIT_OUT) begin
            wd_cnt <= wd_cnt + CW'(1);
        end
    end
`else
    // Watchdog not built: this term is constant false.
    assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    // NOTE: every output is a register, so reset clears them all asynchronously with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            got1        <= 1'b0;
            got2        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            result      <= '0;
            fpu_op      <= '0;
            fpu_in1     <= '0;
            fpu_in2     <= '0;
            fpu_in1_stb <= 1'b0;
            fpu_in2_stb <= 1'b0;
            fpu_out_ack <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make done/err/out_ack single-cycle pulses.
            done        <= 1'b0;
            err         <= 1'b0;
            fpu_out_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        fpu_op  <= op_in;
                        fpu_in1 <= src1;
                        fpu_in2 <= src2;
                        busy    <= 1'b1;
                        if (op_in > LAST_OP) begin
                            state  <= ACK_ERR;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            result <= '0;
                        end else begin
                            state       <= SEND;
                            got1        <= 1'b0;
                            got2        <= 1'b0;
                            fpu_in1_stb <= 1'b1;
                            fpu_in2_stb <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (wd_expired) begin
                        state       <= ACK_ERR;
                        fpu_in1_stb <= 1'b0;
                        fpu_in2_stb <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        result      <= '0;
                    end else begin
                        if (fpu_in1_ack) begin
                            got1        <= 1'b1;
                            fpu_in1_stb <= 1'b0;
                        end
                        if (fpu_in2_ack) begin
                            got2        <= 1'b1;
                            fpu_in2_stb <= 1'b0;
                        end
                        if (both_acked) begin
                            state <= WAIT_OUT;
                        end
                    end
                end

                WAIT_OUT: begin
                    if (wd_expired) begin
                        state  <= ACK_ERR;
                        done   <= 1'b1;
                        err    <= 1'b1;
                        result <= '0;
                    end else if (fpu_out_stb) begin
                        state       <= ACK;
                        result      <= fpu_out;
                        done        <= 1'b1;
                        fpu_out_ack <= 1'b1;
                    end
                end

                ACK, ACK_ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_requester.sv
// Directed, table-driven bench for fpu_requester; the bench plays the FPU controller with scripted ack/out_stb timing.
module tb_fpu_requester;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  op_in;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_in1;
    logic [31:0] fpu_in2;
    logic        fpu_in1_stb;
    logic        fpu_in2_stb;
    logic        fpu_in1_ack;
    logic        fpu_in2_ack;
    logic [31:0] fpu_out;
    logic        fpu_out_stb;
    logic        fpu_out_ack;

    int n_cmp  = 0;
    int n_fail = 0;

    fpu_requester dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op_in       (op_in),
        .src1        (src1),
        .src2        (src2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .err         (err),
        .fpu_op      (fpu_op),
        .fpu_in1     (fpu_in1),
        .fpu_in2     (fpu_in2),
        .fpu_in1_stb (fpu_in1_stb),
        .fpu_in2_stb (fpu_in2_stb),
        .fpu_in1_ack (fpu_in1_ack),
        .fpu_in2_ack (fpu_in2_ack),
        .fpu_out     (fpu_out),
        .fpu_out_stb (fpu_out_stb),
        .fpu_out_ack (fpu_out_ack)
    );

    always #5 clk = ~clk;

    // Cycle numbers are relative to the start cycle C0; 0 in a1/a2/out_at/poke means never.
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] fout;
        int          a1;
        int          a2;
        int          out_at;
        int          poke;
        int          exp_done;
        int          exp_last1;
        int          exp_last2;
        logic        exp_err;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start       = 1'b0;
        op_in       = 4'h0;
        src1        = '0;
        src2        = '0;
        fpu_in1_ack = 1'b0;
        fpu_in2_ack = 1'b0;
        fpu_out     = '0;
        fpu_out_stb = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int   done_cyc = 0;
        int   done_cnt = 0;
        int   ack_cnt  = 0;
        int   last1    = 0;
        int   last2    = 0;
        int   busy_bad = 0;
        int   opnd_bad = 0;
        int   op_bad   = 0;
        logic err_s    = 1'b0;
        logic [31:0] res_s = '0;
        bit   served   = 1'b0;

        @(negedge clk);
        start = 1'b1;
        op_in = v.op;
        src1  = v.s1;
        src2  = v.s2;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            // Scramble the request bus so only latched values can reach the controller.
            start = 1'b0;
            op_in = ~v.op;
            src1  = ~v.s1;
            src2  = ~v.s2;
            if (c == v.poke) begin
                start = 1'b1;
                op_in = 4'b0011;
                src1  = 32'h1234_5678;
            end

            if (busy !== (c <= v.exp_done)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    err_s    = err;
                    res_s    = result;
                end
            end
            if (fpu_out_ack === 1'b1) begin
                ack_cnt++;
                served = 1'b1;
                if (last1 >= c - 1 || last2 >= c - 1) opnd_bad++;
            end
            if (fpu_in1_stb === 1'b1) last1 = c;
            if (fpu_in2_stb === 1'b1) last2 = c;
            if ((fpu_in1_stb | fpu_in2_stb) && (fpu_in1 !== v.s1 || fpu_in2 !== v.s2)) opnd_bad++;
            if (c <= v.exp_done && fpu_op !== v.op) op_bad++;

            fpu_in1_ack = fpu_in1_stb && v.a1 != 0 && c >= v.a1;
            fpu_in2_ack = fpu_in2_stb && v.a2 != 0 && c >= v.a2;
            fpu_out_stb = !served && v.out_at != 0 && c >= v.out_at;
            fpu_out     = fpu_out_stb ? v.fout : 32'hDEAD_BEEF;

            if (done_cyc != 0 && c >= done_cyc + 3) break;
        end
        idle_inputs();

        check({v.name, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        check({v.name, " done_count"}, 32'(done_cnt), 32'd1);
        check({v.name, " err"},        32'(err_s),    32'(v.exp_err));
        check({v.name, " result"},     res_s,         v.exp_res);
        check({v.name, " out_ack_cycles"}, 32'(ack_cnt), v.exp_err ? 32'd0 : 32'd1);
        check({v.name, " in1_stb_last"},   32'(last1),   32'(v.exp_last1));
        check({v.name, " in2_stb_last"},   32'(last2),   32'(v.exp_last2));
        check({v.name, " busy_errors"},    32'(busy_bad), 32'd0);
        check({v.name, " operand_errors"}, 32'(opnd_bad), 32'd0);
        check({v.name, " op_changes"},     32'(op_bad),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        //         name        op       src1          src2          fout          a1 a2 out poke done l1 l2 err res
        vecs[0] = '{"fadd",   4'b0000, 32'h3F800000, 32'h40000000, 32'h40400000, 3, 3, 8,  0,  9,  3, 3, 1'b0, 32'h40400000};
        vecs[1] = '{"fsgnjn", 4'b0111, 32'h3F800000, 32'h3F800000, 32'hBF800000, 1, 1, 1,  3,  3,  1, 1, 1'b0, 32'hBF800000};
        vecs[2] = '{"fmul",   4'b0010, 32'h3FC00000, 32'h40000000, 32'h40400000, 2, 6, 1,  4,  8,  2, 6, 1'b0, 32'h40400000};
        vecs[3] = '{"ill_c",  4'b1100, 32'h11111111, 32'h22222222, 32'h0,        1, 1, 0,  0,  1,  0, 0, 1'b1, 32'h0};
        vecs[4] = '{"fdiv",   4'b0011, 32'h40A00000, 32'h40000000, 32'h40200000, 4, 2, 10, 0,  11, 4, 2, 1'b0, 32'h40200000};
        vecs[5] = '{"ill_b",  4'b1011, 32'h33333333, 32'h44444444, 32'h0,        1, 1, 0,  0,  1,  0, 0, 1'b1, 32'h0};
        vecs[6] = '{"fle",    4'b1010, 32'h3F800000, 32'h40000000, 32'h00000001, 1, 1, 1,  0,  3,  1, 1, 1'b0, 32'h00000001};
        vecs[7] = '{"fsub",   4'b0001, 32'h40400000, 32'h3F800000, 32'h40000000, 1, 1, 3,  0,  4,  1, 1, 1'b0, 32'h40000000};

        idle_inputs();
        reset_n = 1'b0;
        #1;
        check("reset_ctrl", 32'({busy, done, err, fpu_in1_stb, fpu_in2_stb, fpu_out_ack}), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_bus", 32'({fpu_op, fpu_in1 | fpu_in2}), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Reset in WAIT_OUT: acks in C1, no out_stb, reset mid-cycle during C3.
        @(negedge clk);
        start = 1'b1;
        op_in = 4'b0000;
        src1  = 32'h3F800000;
        src2  = 32'h40000000;
        @(negedge clk);
        start       = 1'b0;
        fpu_in1_ack = 1'b1;
        fpu_in2_ack = 1'b1;
        @(negedge clk);
        fpu_in1_ack = 1'b0;
        fpu_in2_ack = 1'b0;
        check("wait_out_busy", 32'(busy), 32'd1);
        check("wait_out_stbs", 32'({fpu_in1_stb, fpu_in2_stb}), 32'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", 32'({busy, done, err, fpu_in1_stb, fpu_in2_stb, fpu_out_ack}), 32'd0);
        check("midrst_bus", 32'({fpu_op, fpu_in1 | fpu_in2}), 32'd0);
        check("midrst_result", result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
